vga_timing_monitor: RTL and testbench
=====================================

Name: vga_timing_monitor

Overview:
- Receive-side counterpart of the chip's VGA output: samples hsync, vsync and the 6-bit rrggbb bus on the pixel clock.
- Recovers line/frame timing, checks it against the nominal mode, reports active-pixel coordinates, and computes a per-frame signature of the active picture.
- Used in silicon loopback and in the testbench to check pattern generators bit-exactly without a screen.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- Derived: H_TOTAL = sum of the H_* values (800); V_TOTAL = sum of the V_* values (525).

Ports:
- clk  in  1  pixel clock, rising edge
- rst  in  1  synchronous reset, active-high
- hsync  in  1  sampled horizontal sync
- vsync  in  1  sampled vertical sync
- rrggbb  in  6  sampled pixel colour {R1,R0,G1,G0,B1,B0}
- pixel_valid  out  1  active-area pixel present on x/y/pixel
- x  out  10  active column, 0..H_ACTIVE-1
- y  out  10  active row, 0..V_ACTIVE-1
- pixel  out  6  registered rrggbb for that x/y
- frame_done  out  1  one-cycle pulse at frame boundary
- frame_sig  out  16  signature of the last completed frame
- frame_good  out  1  last completed frame had fully correct timing
- locked  out  1  timing stable
- err_cnt  out  8  saturating count of timing errors

Behaviour:
Input and edges
- All inputs are registered once (stage S1).
- HA edge: S1 hsync becomes active (previous S1 inactive); HD edge: active-to-inactive.
- VA edge: same definition on vsync.

Horizontal counter
- 11-bit h_cnt: set to 0 on an HA edge, otherwise +1, saturating at 2047.
- HD edge: line width is good iff h_cnt == H_SYNC.
- HA edge: line length is good iff the pre-clear h_cnt == H_TOTAL-1.
- The first HA edge after reset is exempt from the length check.
- A bad line increments err_cnt once, even if it is both too short/long and has a bad width.

Vertical counter
- VA edge sets flag vpend.
- On an HA edge with vpend (a same-cycle VA edge counts): v_cnt <= 0, clear vpend, frame boundary.
- On any other HA edge: v_cnt +1, saturating at 1023.
- Frame length is good iff the pre-clear v_cnt == V_TOTAL-1. The first boundary after reset is exempt.

Active window
- vsync asserts at line start, before that line's hsync, so the window is:
  - horizontal: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE)
  - vertical: v_cnt in [V_SYNC+V_BACK-1, V_SYNC+V_BACK-1+V_ACTIVE)
- x and y are the offsets into that window.
- x, y, pixel and pixel_valid are registered: 2 clk from input pins to outputs.
- Window tracking requires that at least one boundary has been seen since reset; before that, pixel_valid = 0.

Signature
- For each valid pixel: sig <= {sig[14:0],sig[15]} ^ {10'b0,pixel}.
- At a frame boundary:
  - frame_sig <= sig (including any pixel in the same cycle); sig <= 0.
  - frame_done = 1 for one cycle.
  - frame_good <= frame length good AND no bad line since the previous boundary.
- The first boundary after reset only clears sig; no frame_done.

Lock
- locked rises on the boundary that completes the 2nd consecutive good frame.
- locked clears immediately, in the same cycle err_cnt increments, on any bad line or bad frame.
- locked also clears on timeout: h_cnt reaches 2*H_TOTAL with no HA edge. Timeout increments err_cnt once per occurrence.
- After any clear, 2 new consecutive good frames are required to re-lock.

Reset
- rst mid-frame returns all state to the reset values at the next edge.
- Reset values: all outputs 0; h_cnt, v_cnt, sig, vpend, history flags 0.
- err_cnt saturates at 255.

Test Plan:
- Nominal 800x525 timing, rrggbb = 0, 3 frames -> frame_done 2 times (first boundary suppressed); frame_good=1; frame_sig=0x0000; locked=1 after the 3rd boundary; err_cnt=0.
- Constant rrggbb=6'h3F, locked -> pixel_valid high exactly 307200 cycles per frame; x 0..639 / y 0..479 in raster order; pixel = 0x3F lagging input by 2 clk; frame_sig equals the reference model's value.
- One line of 799 clocks after lock -> err_cnt=1; locked=0 on that HA edge; next frame_good=0; locked returns after 2 clean frames.
- hsync pulse of 95 clocks -> bad width, err_cnt +1; a line that is both short and narrow adds only +1.
- hsync held inactive after lock -> locked=0 at h_cnt=1600; err_cnt +1; no further increments until hsync resumes.
- rst pulsed mid-frame -> all outputs 0 next cycle; first subsequent boundary gives no frame_done and no error.

Source files
------------

// File: rtl/vga_timing_monitor_if.sv
// Sampled VGA pins plus the recovered-timing outputs of the monitor.
// The source (pattern generator or bench) uses master; the monitor uses slave.
interface vga_timing_monitor_if;
  logic        hsync;
  logic        vsync;
  logic [5:0]  rrggbb;
  logic        pixel_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [5:0]  pixel;
  logic        frame_done;
  logic [15:0] frame_sig;
  logic        frame_good;
  logic        locked;
  logic [7:0]  err_cnt;

  modport master (
    output hsync, vsync, rrggbb,
    input  pixel_valid, x, y, pixel, frame_done, frame_sig, frame_good, locked, err_cnt
  );

  modport slave (
    input  hsync, vsync, rrggbb,
    output pixel_valid, x, y, pixel, frame_done, frame_sig, frame_good, locked, err_cnt
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA monitor: recovers line/frame timing, checks it against the
// nominal mode, reports active-pixel coordinates and a per-frame signature.
//
// state      | meaning
// S_HUNT     | no clean frame since reset or since the last timing error
// S_ONE_GOOD | one clean frame completed, need one more
// S_LOCKED   | two or more consecutive clean frames, timing stable
module vga_timing_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SYNC_POL = 0
) (
  input logic clk,
  input logic rst,
  vga_timing_monitor_if.slave bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LINE_END = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_WIDTH    = 11'(H_SYNC);
  localparam logic [10:0] H_TO_PRE   = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] H_WIN_LO   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_WIN_HI   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_FRAME_END = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_WIN_LO   = 10'(V_SYNC + V_BACK - 1);
  localparam logic [9:0]  V_WIN_HI   = 10'(V_SYNC + V_BACK - 1 + V_ACTIVE);
  localparam logic        SYNC_LVL   = 1'(SYNC_POL);

  typedef enum logic [1:0] {S_HUNT, S_ONE_GOOD, S_LOCKED} lock_t;

  lock_t       lock_st, lock_next;
  logic        hs_act, hs_act_d, vs_act, vs_act_d;
  logic [5:0]  rgb_s1;
  logic [10:0] h_cnt, h_next;
  logic [9:0]  v_cnt, v_next;
  logic        vpend, seen_ha, seen_bnd, line_err, frame_err;
  logic [15:0] sig, sig_next;
  logic        ha, hd, va, bnd, bnd_chk;
  logic        width_bad, len_bad, line_bad, frame_len_bad, timeout, err_evt;
  logic        frame_ok, in_win;

  // h_next/v_next are the raster position of the sample now held in S1;
  // the registered h_cnt/v_cnt lag that by one sample.
  always_comb begin
    ha  = hs_act & ~hs_act_d;
    hd  = ~hs_act & hs_act_d;
    va  = vs_act & ~vs_act_d;
    bnd = ha & (vpend | va);
    bnd_chk = bnd & seen_bnd;

    h_next = h_cnt;
    if (ha)                 h_next = '0;
    else if (h_cnt != '1)   h_next = h_cnt + 11'd1;

    v_next = v_cnt;
    if (bnd)                v_next = '0;
    else if (ha && v_cnt != '1) v_next = v_cnt + 10'd1;

    width_bad     = hd & (h_next != H_WIDTH);
    len_bad       = ha & seen_ha & (h_cnt != H_LINE_END);
    line_bad      = width_bad | (len_bad & ~line_err);
    frame_len_bad = bnd_chk & (v_cnt != V_FRAME_END);
    timeout       = ~ha & (h_cnt == H_TO_PRE);
    err_evt       = line_bad | frame_len_bad | timeout;
    frame_ok      = ~frame_len_bad & ~frame_err & ~line_bad & ~timeout;

    in_win = seen_bnd & (h_next >= H_WIN_LO) & (h_next < H_WIN_HI)
                      & (v_next >= V_WIN_LO) & (v_next < V_WIN_HI);

    sig_next = sig;
    if (bus.pixel_valid) sig_next = {sig[14:0], sig[15]} ^ {10'b0, bus.pixel};
  end

  always_comb begin
    lock_next = lock_st;
    if (err_evt) begin
      lock_next = S_HUNT;
    end else if (bnd_chk) begin
      if (!frame_ok)                 lock_next = S_HUNT;
      else if (lock_st == S_HUNT)    lock_next = S_ONE_GOOD;
      else                           lock_next = S_LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lock_st <= S_HUNT;
    else     lock_st <= lock_next;
  end

  assign bus.locked = (lock_st == S_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_act         <= 1'b0;
      hs_act_d       <= 1'b0;
      vs_act         <= 1'b0;
      vs_act_d       <= 1'b0;
      rgb_s1         <= '0;
      h_cnt          <= '0;
      v_cnt          <= '0;
      vpend          <= 1'b0;
      seen_ha        <= 1'b0;
      seen_bnd       <= 1'b0;
      line_err       <= 1'b0;
      frame_err      <= 1'b0;
      sig            <= '0;
      bus.pixel_valid <= 1'b0;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.pixel      <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_sig  <= '0;
      bus.frame_good <= 1'b0;
      bus.err_cnt    <= '0;
    end else begin
      hs_act   <= (bus.hsync == SYNC_LVL);
      vs_act   <= (bus.vsync == SYNC_LVL);
      hs_act_d <= hs_act;
      vs_act_d <= vs_act;
      rgb_s1   <= bus.rrggbb;
      h_cnt    <= h_next;
      v_cnt    <= v_next;

      if (bnd)     vpend <= 1'b0;
      else if (va) vpend <= 1'b1;
      if (ha)  seen_ha  <= 1'b1;
      if (bnd) seen_bnd <= 1'b1;

      // A line already flagged for width is not charged again for length.
      if (ha)             line_err <= 1'b0;
      else if (width_bad) line_err <= 1'b1;

      if (bnd)                       frame_err <= 1'b0;
      else if (line_bad || timeout)  frame_err <= 1'b1;

      if (err_evt && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;

      bus.pixel_valid <= in_win;
      if (in_win) begin
        bus.x     <= 10'(h_next - H_WIN_LO);
        bus.y     <= v_next - V_WIN_LO;
        bus.pixel <= rgb_s1;
      end

      sig            <= bnd ? 16'h0000 : sig_next;
      bus.frame_done <= bnd_chk;
      if (bnd_chk) begin
        bus.frame_sig  <= sig_next;
        bus.frame_good <= frame_ok;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced 15x9 video mode so
// that many whole frames fit in a short run.
module tb_vga_timing_monitor;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int NPIX = HA * VA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_monitor_if bus ();

  vga_timing_monitor #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_ha_cyc = 0;
  int          done_cnt = 0;
  int          vcnt = 0;
  bit          mon_armed = 0;
  bit          pix_chk = 0;
  bit          to_watch = 0;
  bit          rst_chk = 0;
  bit          prev_hs = 0;
  logic [7:0]  last_err = '0;
  logic [15:0] msig = '0;
  int          p0_v = 0, p0_x = 0, p0_y = 0, p0_px = 0;
  int          p1_v = 0, p1_x = 0, p1_y = 0, p1_px = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_pixel_valid"}, bus.pixel_valid, 0);
    chk({pfx, "_x"}, bus.x, 0);
    chk({pfx, "_y"}, bus.y, 0);
    chk({pfx, "_pixel"}, bus.pixel, 0);
    chk({pfx, "_frame_done"}, bus.frame_done, 0);
    chk({pfx, "_frame_sig"}, bus.frame_sig, 0);
    chk({pfx, "_frame_good"}, bus.frame_good, 0);
    chk({pfx, "_locked"}, bus.locked, 0);
    chk({pfx, "_err_cnt"}, bus.err_cnt, 0);
  endtask

  function automatic logic [5:0] pat(input int mode, input int h, input int v);
    if (mode == 0) return 6'h00;
    if (mode == 1) return 6'h3F;
    return 6'(h * 5 + v * 7 + mode);
  endfunction

  // One pixel clock: check outputs for the sample driven two cycles ago, then drive.
  task automatic step(input bit hs, input bit vs, input logic [5:0] rgb,
                      input bit ev, input int ex, input int ey, input bit do_rst);
    @(negedge clk);
    if (rst_chk) begin
      chk_zero("midrst");
      rst_chk = 0;
    end
    if (pix_chk) begin
      chk("pixel_valid", bus.pixel_valid, p1_v);
      if (p1_v != 0) begin
        chk("x", bus.x, p1_x);
        chk("y", bus.y, p1_y);
        chk("pixel", bus.pixel, p1_px);
      end
    end
    if (bus.pixel_valid === 1'b1) vcnt++;
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.err_cnt !== last_err) begin
      chk("locked_on_err", bus.locked, 0);
      if (to_watch) chk("timeout_latency", cyc - last_ha_cyc, 2 * HT + 2);
      last_err = bus.err_cnt;
    end
    p1_v = p0_v; p1_x = p0_x; p1_y = p0_y; p1_px = p0_px;
    p0_v = ev; p0_x = ex; p0_y = ey; p0_px = rgb;
    if (hs && !prev_hs) last_ha_cyc = cyc;
    prev_hs = hs;
    bus.hsync  = hs ? 1'b0 : 1'b1;
    bus.vsync  = vs ? 1'b0 : 1'b1;
    bus.rrggbb = rgb;
    rst = do_rst;
    if (do_rst) begin
      rst_chk = 1;
      mon_armed = 0;
      done_cnt = 0;
      p0_v = 0;
      p1_v = 0;
    end
    cyc++;
  endtask

  task automatic run_frame(input int mode, input int short_ln, input int narrow_ln,
                           input int nohs_from, input int rst_ln);
    msig = '0;
    vcnt = 0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        bit hs, vs, act, ev, dr;
        int hw;
        logic [5:0] rgb;
        if (v == short_ln && h == HT - 1) continue;
        hw  = (v == narrow_ln) ? HS - 1 : HS;
        hs  = (h >= HA + HF) && (h < HA + HF + hw) && !(nohs_from >= 0 && v >= nohs_from);
        vs  = (v >= VA + VF) && (v < VA + VF + VS);
        act = (h < HA) && (v < VA);
        rgb = act ? pat(mode, h, v) : 6'h00;
        ev  = act && mon_armed;
        if (ev) msig = {msig[14:0], msig[15]} ^ {10'b0, rgb};
        dr  = (v == rst_ln) && (h == 0);
        step(hs, vs, rgb, ev, h, v, dr);
        if (v == VA + VF && h == HA + HF && hs) mon_armed = 1;
      end
    end
  endtask

  initial begin
    bus.hsync  = 1'b1;
    bus.vsync  = 1'b1;
    bus.rrggbb = 6'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // nominal timing, black picture
    pix_chk = 1;
    run_frame(0, -1, -1, -1, -1);
    chk("f0_frame_done_cnt", done_cnt, 0);
    chk("f0_valid_cnt", vcnt, 0);
    run_frame(0, -1, -1, -1, -1);
    chk("f1_frame_done_cnt", done_cnt, 1);
    chk("f1_locked", bus.locked, 0);
    chk("f1_frame_good", bus.frame_good, 1);
    chk("f1_valid_cnt", vcnt, NPIX);
    run_frame(0, -1, -1, -1, -1);
    chk("f2_frame_done_cnt", done_cnt, 2);
    chk("f2_frame_sig", bus.frame_sig, 16'h0000);
    chk("f2_locked", bus.locked, 1);
    chk("f2_err_cnt", bus.err_cnt, 0);

    // constant and varying pictures while locked
    run_frame(1, -1, -1, -1, -1);
    chk("f3_valid_cnt", vcnt, NPIX);
    chk("f3_frame_sig", bus.frame_sig, msig);
    chk("f3_locked", bus.locked, 1);
    run_frame(2, -1, -1, -1, -1);
    chk("f4_frame_sig", bus.frame_sig, msig);
    chk("f4_frame_good", bus.frame_good, 1);

    // one line one clock short
    pix_chk = 0;
    run_frame(2, 1, -1, -1, -1);
    chk("f5_err_cnt", bus.err_cnt, 1);
    chk("f5_locked", bus.locked, 0);
    chk("f5_frame_good", bus.frame_good, 0);
    pix_chk = 1;
    run_frame(3, -1, -1, -1, -1);
    chk("f6_frame_good", bus.frame_good, 1);
    chk("f6_locked", bus.locked, 0);
    chk("f6_frame_sig", bus.frame_sig, msig);
    run_frame(4, -1, -1, -1, -1);
    chk("f7_locked", bus.locked, 1);
    chk("f7_err_cnt", bus.err_cnt, 1);

    // narrow hsync, then narrow and short on the same line
    pix_chk = 0;
    run_frame(2, -1, 1, -1, -1);
    chk("f8_err_cnt", bus.err_cnt, 2);
    chk("f8_locked", bus.locked, 0);
    run_frame(2, 1, 1, -1, -1);
    chk("f9_err_cnt", bus.err_cnt, 3);
    chk("f9_frame_good", bus.frame_good, 0);
    pix_chk = 1;
    run_frame(5, -1, -1, -1, -1);
    chk("f10_locked", bus.locked, 0);
    chk("f10_err_cnt", bus.err_cnt, 3);
    run_frame(6, -1, -1, -1, -1);
    chk("f11_locked", bus.locked, 1);
    chk("f11_frame_sig", bus.frame_sig, msig);

    // hsync stops after line 0
    pix_chk = 0;
    to_watch = 1;
    run_frame(2, -1, -1, 1, -1);
    to_watch = 0;
    chk("f12_err_cnt", bus.err_cnt, 4);
    chk("f12_locked", bus.locked, 0);

    // reset in the middle of a frame
    run_frame(2, -1, -1, -1, 2);
    chk("f13_frame_done_cnt", done_cnt, 0);
    chk("f13_err_cnt", bus.err_cnt, 0);
    pix_chk = 1;
    run_frame(7, -1, -1, -1, -1);
    chk("f14_frame_good", bus.frame_good, 1);
    chk("f14_valid_cnt", vcnt, NPIX);
    run_frame(8, -1, -1, -1, -1);
    chk("f15_frame_done_cnt", done_cnt, 2);
    chk("f15_locked", bus.locked, 1);
    chk("f15_err_cnt", bus.err_cnt, 0);
    chk("f15_frame_sig", bus.frame_sig, msig);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
